plru_way_controller: RTL and testbench
======================================

Name: plru_way_controller

Overview:
- Per-set tree pseudo-LRU way controller for the set-associative unified cache.
- On every lookup it produces the one-hot way select for the way-select mux: the hit way on a hit, or the replacement victim on a miss.
- It also maintains the replacement state for every set.
- It sits between tag-compare logic (upstream) and the way-select mux / refill path (downstream).

Parameters:
- NUMBER_WAYS, 8, ways per set; power of two, >=2.
- NUMBER_SETS, 16, sets tracked; power of two, >=2.
- SET_PTR_WIDTH, $clog2(NUMBER_SETS), set index width (derived, not overridden).

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous active-high reset.
- access_valid_in  input  1  lookup request this cycle.
- access_ready_out  output  1  controller accepts a lookup this cycle.
- access_set_in  input  SET_PTR_WIDTH  set index of the lookup.
- access_hit_in  input  1  tag compare reported a hit.
- access_hit_way_in  input  NUMBER_WAYS  one-hot hit way; ignored on a miss.
- valid_ways_in  input  NUMBER_WAYS  per-way valid bits of the addressed set.
- flush_in  input  1  pulse; clears all PLRU state by sweep.
- result_valid_out  output  1  result strobe, one cycle.
- result_way_out  output  NUMBER_WAYS  one-hot way; drives the mux sel_in.
- result_is_victim_out  output  1  result is a replacement victim (miss).
- error_out  output  1  pulse: hit with a non-one-hot hit way.

Behaviour:
- State storage: NUMBER_SETS x (NUMBER_WAYS-1) flop array, one binary tree per set.
  - Node i has children 2i+1 and 2i+2.
  - Bit=0 means the victim lies in the left subtree (lower way indices); bit=1 means the right subtree.
- Reset: all tree bits 0; FSM to IDLE.
  - result_valid_out=0, result_way_out=0, result_is_victim_out=0, error_out=0, access_ready_out=1 from the first cycle after reset.
- FSM states: IDLE and FLUSH.
  - IDLE: access_ready_out=1.
  - flush_in in IDLE: go to FLUSH with sweep counter=0. access_ready_out=0 from the next cycle.
  - FLUSH: clears one set per cycle (set[counter]<=0). After NUMBER_SETS cycles, return to IDLE.
  - flush_in while in FLUSH is ignored.
- Handshake: a lookup is accepted when access_valid_in && access_ready_out. Throughput is 1 lookup/cycle.
  - A lookup and flush_in in the same IDLE cycle: the lookup completes (including its tree write), then FLUSH starts.
- Latency: results are registered and appear exactly 1 cycle after acceptance. result_valid_out pulses high for 1 cycle. All other result outputs hold their value.
- Hit with a one-hot access_hit_way_in:
  - result_way_out=hit way, result_is_victim_out=0.
  - Update the set tree as an access to that way.
- Hit with a zero or multi-hot access_hit_way_in:
  - result_valid_out=1, result_way_out=0 (the mux then outputs 0), error_out=1 for 1 cycle.
  - No tree update.
- Miss:
  - If valid_ways_in != all-ones, the victim is the lowest-indexed way with a 0 valid bit.
  - Otherwise the victim is the tree walk: start at the root, follow the bits to a leaf.
  - result_is_victim_out=1.
  - Update the tree as an access to the victim.
- Tree update on access to way w: every node on w's path is set to point away from w. A node is set to 1 if w is in its left subtree, 0 if in its right.
- Back-to-back same-set lookups: the tree is read combinationally and written at the clock edge. The second lookup must see the first lookup's update, so no stall is allowed.
- Reset mid-FLUSH or mid-lookup: reset wins. All state is cleared and the pending result is dropped (result_valid_out=0 next cycle).

Decomposition:
- Shared package cache_pkg holds:
  - NUMBER_WAYS/NUMBER_SETS defaults.
  - The tree node-count constant (NUMBER_WAYS-1).
  - The FSM state encoding (IDLE, FLUSH).
- One combinational sub-module, plru_tree_logic.
  - Inputs: tree bits, access way.
  - Outputs: victim one-hot, next tree bits.
  - Reused by the I and D cache configurations.

Test Plan:
- Reset, then 4 misses to set 3 with valid_ways_in=0xFF -> result_way_out 0x01, 0x10, 0x04, 0x40 in order, each with result_is_victim_out=1 and 1-cycle latency.
- Miss to set 5 with valid_ways_in=0xEB -> result_way_out=0x04 (lowest invalid way). A following miss with valid=0xFF -> 0x10.
- Hit set 0 with way 0x01, then an immediate miss on set 0 with valid=0xFF -> 0x01 then 0x10. The back-to-back update is visible with no bubble.
- Hit with access_hit_way_in=0x18 -> error_out=1, result_way_out=0x00, result_valid_out=1. The next miss still returns 0x01 (tree untouched).
- Two misses to set 2, flush_in, then 16 cycles with access_ready_out=0, then a miss to set 2 -> 0x01.
- Reset asserted during FLUSH cycle 7 -> ready=1 after reset, all outputs 0, and the set 15 victim = 0x01.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-replacement constants and types used by the PLRU way controller
// and its tree logic (I- and D-cache configurations).
package cache_pkg;

  localparam int DEFAULT_NUMBER_WAYS = 8;
  localparam int DEFAULT_NUMBER_SETS = 16;
  localparam int DEFAULT_TREE_NODES  = DEFAULT_NUMBER_WAYS - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } plru_state_e;

  // A binary tree over N leaves has N-1 internal nodes.
  function automatic int tree_nodes(input int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/plru_way_controller_if.sv
// Lookup/result bus between tag compare (master) and the PLRU way controller (slave).
interface plru_way_controller_if
  import cache_pkg::*;
#(
  parameter int NUMBER_WAYS = DEFAULT_NUMBER_WAYS,
  parameter int NUMBER_SETS = DEFAULT_NUMBER_SETS
) ();

  localparam int SET_PTR_WIDTH = $clog2(NUMBER_SETS);

  logic                     access_valid_in;
  logic                     access_ready_out;
  logic [SET_PTR_WIDTH-1:0] access_set_in;
  logic                     access_hit_in;
  logic [NUMBER_WAYS-1:0]   access_hit_way_in;
  logic [NUMBER_WAYS-1:0]   valid_ways_in;
  logic                     flush_in;
  logic                     result_valid_out;
  logic [NUMBER_WAYS-1:0]   result_way_out;
  logic                     result_is_victim_out;
  logic                     error_out;

  modport master (
    output access_valid_in, access_set_in, access_hit_in, access_hit_way_in,
           valid_ways_in, flush_in,
    input  access_ready_out, result_valid_out, result_way_out,
           result_is_victim_out, error_out
  );

  modport slave (
    input  access_valid_in, access_set_in, access_hit_in, access_hit_way_in,
           valid_ways_in, flush_in,
    output access_ready_out, result_valid_out, result_way_out,
           result_is_victim_out, error_out
  );

endinterface

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU logic for one set: victim lookup by tree walk and
// next tree state after an access to a given one-hot way.
module plru_tree_logic
  import cache_pkg::*;
#(
  parameter int NUMBER_WAYS = DEFAULT_NUMBER_WAYS
) (
  input  logic [NUMBER_WAYS-2:0] tree_bits_i,
  input  logic [NUMBER_WAYS-1:0] access_way_i,
  output logic [NUMBER_WAYS-1:0] victim_way_o,
  output logic [NUMBER_WAYS-2:0] tree_next_o
);

  localparam int LEVELS = $clog2(NUMBER_WAYS);

  genvar gi, gj;

  // Exactly one leaf has a path whose directions agree with every node bit on it.
  for (gi = 0; gi < NUMBER_WAYS; gi++) begin : gen_victim
    logic [LEVELS-1:0] path_match;
    for (gj = 0; gj < LEVELS; gj++) begin : gen_level
      localparam int NODE = (1 << gj) - 1 + (gi >> (LEVELS - gj));
      localparam bit DIR  = 1'((gi >> (LEVELS - 1 - gj)) & 1);
      assign path_match[gj] = (tree_bits_i[NODE] == DIR);
    end
    assign victim_way_o[gi] = &path_match;
  end

  // Each node points away from whichever half of its subtree was just accessed.
  for (gi = 0; gi < LEVELS; gi++) begin : gen_node_level
    for (gj = 0; gj < (1 << gi); gj++) begin : gen_node
      localparam int NODE = (1 << gi) - 1 + gj;
      localparam int HALF = NUMBER_WAYS >> (gi + 1);
      localparam int LO   = gj * 2 * HALF;
      logic in_left;
      logic in_right;
      assign in_left  = |access_way_i[LO +: HALF];
      assign in_right = |access_way_i[LO + HALF +: HALF];
      assign tree_next_o[NODE] = in_left  ? 1'b1 :
                                 in_right ? 1'b0 : tree_bits_i[NODE];
    end
  end

endmodule

// File: rtl/plru_way_controller.sv
// Per-set tree pseudo-LRU way controller: one-hot way select (hit way or victim)
// one cycle after each accepted lookup, plus a set-by-set flush sweep.
module plru_way_controller
  import cache_pkg::*;
#(
  parameter int NUMBER_WAYS = DEFAULT_NUMBER_WAYS,
  parameter int NUMBER_SETS = DEFAULT_NUMBER_SETS
) (
  input logic                  clk_in,
  input logic                  reset_in,
  plru_way_controller_if.slave bus_if
);

  localparam int SET_PTR_WIDTH = $clog2(NUMBER_SETS);
  localparam int TREE_NODES    = tree_nodes(NUMBER_WAYS);
  localparam logic [SET_PTR_WIDTH-1:0] LAST_SET = SET_PTR_WIDTH'(NUMBER_SETS - 1);

  plru_state_e              state_q, state_d;
  logic [SET_PTR_WIDTH-1:0] sweep_q, sweep_d;
  logic [TREE_NODES-1:0]    tree_q [NUMBER_SETS];

  logic                     ready;
  logic                     accept;
  logic                     hit_onehot;
  logic                     hit_error;
  logic                     tree_write;
  logic [TREE_NODES-1:0]    tree_cur;
  logic [TREE_NODES-1:0]    tree_next;
  logic [NUMBER_WAYS-1:0]   hit_way;
  logic [NUMBER_WAYS-1:0]   valid_ways;
  logic [NUMBER_WAYS-1:0]   tree_victim;
  logic [NUMBER_WAYS-1:0]   free_way;
  logic [NUMBER_WAYS-1:0]   access_way;
  logic [NUMBER_WAYS-1:0]   result_way_d;

  logic                     result_valid_q;
  logic [NUMBER_WAYS-1:0]   result_way_q;
  logic                     result_is_victim_q;
  logic                     error_q;

  assign ready      = (state_q == IDLE);
  assign accept     = bus_if.access_valid_in && ready;
  assign hit_way    = bus_if.access_hit_way_in;
  assign valid_ways = bus_if.valid_ways_in;

  assign hit_onehot = (hit_way != '0) &&
                      ((hit_way & (hit_way - NUMBER_WAYS'(1))) == '0);
  assign hit_error  = bus_if.access_hit_in && !hit_onehot;

  // Lowest clear bit of the valid mask: ~v & (v + 1).
  assign free_way   = ~valid_ways & (valid_ways + NUMBER_WAYS'(1));

  // Combinational read so a same-set lookup next cycle sees this cycle's write.
  assign tree_cur   = tree_q[bus_if.access_set_in];

  plru_tree_logic #(
    .NUMBER_WAYS (NUMBER_WAYS)
  ) u_tree_logic (
    .tree_bits_i  (tree_cur),
    .access_way_i (access_way),
    .victim_way_o (tree_victim),
    .tree_next_o  (tree_next)
  );

  always_comb begin
    access_way = '0;
    if (bus_if.access_hit_in) begin
      access_way = hit_way;
    end else if (&valid_ways) begin
      access_way = tree_victim;
    end else begin
      access_way = free_way;
    end
  end

  assign result_way_d = hit_error ? '0 : access_way;
  assign tree_write   = accept && !hit_error;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (bus_if.flush_in) begin
          state_d = FLUSH;
          sweep_d = '0;
        end
      end
      FLUSH: begin
        sweep_d = sweep_q + SET_PTR_WIDTH'(1);
        if (sweep_q == LAST_SET) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q            <= IDLE;
      sweep_q            <= '0;
      result_valid_q     <= 1'b0;
      result_way_q       <= '0;
      result_is_victim_q <= 1'b0;
      error_q            <= 1'b0;
      for (int s = 0; s < NUMBER_SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sweep_q        <= sweep_d;
      result_valid_q <= accept;
      error_q        <= accept && hit_error;
      if (accept) begin
        result_way_q       <= result_way_d;
        result_is_victim_q <= !bus_if.access_hit_in;
      end
      if (state_q == FLUSH) begin
        tree_q[sweep_q] <= '0;
      end else if (tree_write) begin
        tree_q[bus_if.access_set_in] <= tree_next;
      end
    end
  end

  assign bus_if.access_ready_out     = ready;
  assign bus_if.result_valid_out     = result_valid_q;
  assign bus_if.result_way_out       = result_way_q;
  assign bus_if.result_is_victim_out = result_is_victim_q;
  assign bus_if.error_out            = error_q;

endmodule

// File: tb/tb_plru_way_controller.sv
// Bench for plru_way_controller: directed scenarios plus randomized lookups
// checked against a node-walk PLRU reference model.
module tb_plru_way_controller;

  localparam int NW    = 8;
  localparam int NS    = 16;
  localparam int SW    = 4;
  localparam int NODES = NW - 1;

  logic clk_in = 1'b0;
  logic reset_in;

  always #5 clk_in = ~clk_in;

  plru_way_controller_if #(.NUMBER_WAYS(NW), .NUMBER_SETS(NS)) bus ();

  plru_way_controller #(
    .NUMBER_WAYS (NW),
    .NUMBER_SETS (NS)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus_if   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one bit per tree node, node n has children 2n+1 and 2n+2.
  bit model_tree [NS][NODES];

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NODES; n++)
        model_tree[s][n] = 1'b0;
  endfunction

  function automatic int model_walk(input int set);
    int node = 0;
    while (node < NODES) node = 2 * node + 1 + int'(model_tree[set][node]);
    return node - NODES;
  endfunction

  function automatic void model_touch(input int set, input int way);
    int n = way + NODES;
    while (n > 0) begin
      int p = (n - 1) / 2;
      model_tree[set][p] = (n % 2 == 1);
      n = p;
    end
  endfunction

  function automatic void model_lookup(input int set, input bit hit,
                                       input logic [NW-1:0] hit_way,
                                       input logic [NW-1:0] valid,
                                       output logic [NW-1:0] exp_way,
                                       output bit exp_victim, output bit exp_err);
    int w = -1;
    exp_way = '0;
    exp_victim = 1'b0;
    exp_err = 1'b0;
    if (hit) begin
      if ($countones(hit_way) != 1) begin
        exp_err = 1'b1;
      end else begin
        for (int i = 0; i < NW; i++) if (hit_way[i]) w = i;
        model_touch(set, w);
        exp_way = hit_way;
      end
    end else begin
      exp_victim = 1'b1;
      for (int i = 0; i < NW; i++) if (!valid[i] && w < 0) w = i;
      if (w < 0) w = model_walk(set);
      exp_way = NW'(1) << w;
      model_touch(set, w);
    end
  endfunction

  task automatic drive(input bit valid, input int set, input bit hit,
                       input logic [NW-1:0] hit_way, input logic [NW-1:0] vways,
                       input bit flush);
    bus.access_valid_in   = valid;
    bus.access_set_in     = SW'(set);
    bus.access_hit_in     = hit;
    bus.access_hit_way_in = hit_way;
    bus.valid_ways_in     = vways;
    bus.flush_in          = flush;
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic lookup(input int set, input bit hit, input logic [NW-1:0] hw,
                        input logic [NW-1:0] vw, output logic [NW+2:0] obs);
    logic [NW-1:0] ew;
    bit ev, ee;
    drive(1'b1, set, hit, hw, vw, 1'b0);
    model_lookup(set, hit, hw, vw, ew, ev, ee);
    tick();
    obs = {bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out, bus.error_out};
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, '0, '1, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    drive(1'b0, 0, 1'b0, '0, '1, 1'b0);
    repeat (2) tick();
    reset_in = 1'b0;
    model_clear();
    checks++;
    if (bus.access_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", bus.access_ready_out);
    end
    checks++;
    if ({bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out, bus.error_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b way=%02h vic=%b err=%b want all 0",
               bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out, bus.error_out);
    end
  endtask

  task automatic test_victim_walk();
    logic [7:0] exp_seq [4] = '{8'h01, 8'h10, 8'h04, 8'h40};
    logic [NW+2:0] obs;
    for (int i = 0; i < 4; i++) begin
      lookup(3, 1'b0, '0, 8'hFF, obs);
      checks++;
      if (obs !== {1'b1, exp_seq[i], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL victim_walk[%0d]: got v=%b way=%02h vic=%b err=%b want v=1 way=%02h vic=1 err=0",
                 i, obs[NW+2], obs[NW+1:2], obs[1], obs[0], exp_seq[i]);
      end
    end
    idle();
    checks++;
    if ({bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out} !== {1'b0, 8'h40, 1'b1}) begin
      failures++;
      $display("FAIL result_hold: got v=%b way=%02h vic=%b want v=0 way=40 vic=1",
               bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out);
    end
  endtask

  task automatic test_invalid_fill();
    logic [NW+2:0] obs;
    lookup(5, 1'b0, '0, 8'hEB, obs);
    checks++;
    if (obs !== {1'b1, 8'h04, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL invalid_fill: got way=%02h v=%b vic=%b want way=04", obs[NW+1:2], obs[NW+2], obs[1]);
    end
    lookup(5, 1'b0, '0, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL fill_then_walk: got way=%02h v=%b vic=%b want way=10", obs[NW+1:2], obs[NW+2], obs[1]);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [NW+2:0] obs;
    lookup(0, 1'b1, 8'h01, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_hit: got v=%b way=%02h vic=%b err=%b want v=1 way=01 vic=0 err=0",
               obs[NW+2], obs[NW+1:2], obs[1], obs[0]);
    end
    lookup(0, 1'b0, '0, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_miss: got v=%b way=%02h vic=%b want v=1 way=10 vic=1",
               obs[NW+2], obs[NW+1:2], obs[1]);
    end
    idle();
  endtask

  task automatic test_bad_hit();
    logic [NW+2:0] obs;
    lookup(1, 1'b1, 8'h18, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bad_hit_multi: got v=%b way=%02h vic=%b err=%b want v=1 way=00 vic=0 err=1",
               obs[NW+2], obs[NW+1:2], obs[1], obs[0]);
    end
    lookup(1, 1'b1, 8'h00, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bad_hit_zero: got v=%b way=%02h err=%b want v=1 way=00 err=1",
               obs[NW+2], obs[NW+1:2], obs[0]);
    end
    lookup(1, 1'b0, '0, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL bad_hit_untouched: got way=%02h err=%b want way=01 err=0", obs[NW+1:2], obs[0]);
    end
    idle();
    checks++;
    if (bus.error_out !== 1'b0) begin
      failures++;
      $display("FAIL error_pulse: got %b want 0", bus.error_out);
    end
  endtask

  task automatic test_flush();
    logic [NW+2:0] obs;
    int cnt = 0;
    int stray = 0;
    lookup(2, 1'b0, '0, 8'hFF, obs);
    lookup(2, 1'b0, '0, 8'hFF, obs);
    // Lookup and flush in the same cycle: lookup completes, then the sweep starts.
    drive(1'b1, 6, 1'b0, '0, 8'hFF, 1'b1);
    tick();
    checks++;
    if ({bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out} !== {1'b1, 8'h01, 1'b1}) begin
      failures++;
      $display("FAIL lookup_with_flush: got v=%b way=%02h vic=%b want v=1 way=01 vic=1",
               bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out);
    end
    drive(1'b1, 2, 1'b0, '0, 8'hFF, 1'b0);
    while (bus.access_ready_out !== 1'b1 && cnt < 40) begin
      cnt++;
      bus.flush_in = (cnt == 3);
      tick();
      if (bus.result_valid_out !== 1'b0) stray++;
    end
    bus.flush_in = 1'b0;
    model_clear();
    checks++;
    if (cnt != NS) begin
      failures++;
      $display("FAIL flush_busy_cycles: got %0d want %0d", cnt, NS);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL flush_no_accept: got %0d results during flush want 0", stray);
    end
    lookup(2, 1'b0, '0, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flush_cleared: got v=%b way=%02h want v=1 way=01", obs[NW+2], obs[NW+1:2]);
    end
    idle();
  endtask

  task automatic test_reset_mid_flush();
    logic [NW+2:0] obs;
    lookup(15, 1'b0, '0, 8'hFF, obs);
    lookup(15, 1'b0, '0, 8'hFF, obs);
    drive(1'b0, 0, 1'b0, '0, 8'hFF, 1'b1);
    tick();
    bus.flush_in = 1'b0;
    repeat (6) tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    model_clear();
    checks++;
    if (bus.access_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_flush_ready: got %b want 1", bus.access_ready_out);
    end
    checks++;
    if ({bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out, bus.error_out} !== '0) begin
      failures++;
      $display("FAIL reset_mid_flush_outputs: got v=%b way=%02h vic=%b err=%b want all 0",
               bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out, bus.error_out);
    end
    lookup(15, 1'b0, '0, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_flush_set15: got way=%02h want 01", obs[NW+1:2]);
    end
    // Reset in the same cycle as an accepted lookup drops it entirely.
    drive(1'b1, 9, 1'b0, '0, 8'hFF, 1'b0);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    model_clear();
    checks++;
    if (bus.result_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_result: got v=%b want 0", bus.result_valid_out);
    end
    lookup(9, 1'b0, '0, 8'hFF, obs);
    checks++;
    if (obs !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_drops_update: got way=%02h want 01", obs[NW+1:2]);
    end
    idle();
  endtask

  task automatic test_random();
    logic [NW-1:0] hw, vw, ew, last_way;
    bit ev, ee, last_vic, req, hit;
    int set;
    reset_in = 1'b1;
    drive(1'b0, 0, 1'b0, '0, '1, 1'b0);
    tick();
    reset_in = 1'b0;
    model_clear();
    last_way = '0;
    last_vic = 1'b0;
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 99) < 85);
      set = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(0, 2));
      hit = ($urandom_range(0, 99) < 40);
      hw  = NW'(1) << $urandom_range(0, NW - 1);
      if ($urandom_range(0, 19) == 0) begin
        hw = NW'($urandom);
        if ($countones(hw) == 1) hw = '0;
      end
      vw = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '1;
      drive(req, set, hit, hw, vw, 1'b0);
      tick();
      if (req) begin
        model_lookup(set, hit, hw, vw, ew, ev, ee);
        last_way = ew;
        last_vic = ev;
      end else begin
        ew = last_way;
        ev = last_vic;
        ee = 1'b0;
      end
      checks++;
      if ({bus.result_valid_out, bus.result_way_out, bus.result_is_victim_out, bus.error_out}
          !== {req, ew, ev, ee}) begin
        failures++;
        $display("FAIL random[%0d] set=%0d hit=%b hw=%02h vw=%02h: got v=%b way=%02h vic=%b err=%b want v=%b way=%02h vic=%b err=%b",
                 i, set, hit, hw, vw, bus.result_valid_out, bus.result_way_out,
                 bus.result_is_victim_out, bus.error_out, req, ew, ev, ee);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_victim_walk();
    test_invalid_fill();
    test_back_to_back();
    test_bad_hit();
    test_flush();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
